// File: rtl/game_display_ctrl.sv
// Game-flow sequencer and palette driver for the pixel colour multiplexer.
// Define PALETTE_DIM_EN to halve every colour nibble while paused.
module game_display_ctrl #(
  parameter int unsigned SERVE_FRAMES = 4,
  parameter int unsigned FLASH_FRAMES = 6,
  parameter int unsigned WIN_SCORE    = 9
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_tick,
  input  logic        start_btn,
  input  logic        pause_btn,
  input  logic        score1_evt,
  input  logic        score2_evt,
  output logic [11:0] pad1_rgb,
  output logic [11:0] pad2_rgb,
  output logic [11:0] ball_rgb,
  output logic [11:0] bg_rgb,
  output logic        game_run,
  output logic        ball_visible,
  output logic [3:0]  score1,
  output logic [3:0]  score2
);

`ifdef PALETTE_DIM_EN
  localparam bit DimEn = 1'b1;
`else
  localparam bit DimEn = 1'b0;
`endif

  localparam logic [11:0] Pad1Rgb  = 12'hAAA;
  localparam logic [11:0] Pad2Rgb  = 12'hF00;
  localparam logic [11:0] BallRgb  = 12'h0FF;
  localparam logic [11:0] BgRgb    = 12'hFFF;
  localparam logic [7:0]  ServeCnt = 8'(SERVE_FRAMES);
  localparam logic [7:0]  FlashCnt = 8'(FLASH_FRAMES);
  localparam logic [3:0]  WinScore = 4'(WIN_SCORE);

  typedef enum logic [2:0] {
    StIdle, StServe, StPlay, StFlash, StPause, StOver
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  score1_q, score1_d, score2_q, score2_d;
  logic        scorer_q, scorer_d;      // 0: player 1, 1: player 2
  logic        flash_on_q, flash_on_d;  // 1: background shows scorer colour
  logic [11:0] pad1_q, pad1_d, pad2_q, pad2_d, ball_q, ball_d, bg_q, bg_d;
  logic        run_q, run_d, vis_q, vis_d;
  logic [11:0] scorer_rgb;
  logic [3:0]  scorer_score;

  function automatic logic [11:0] dim(input logic [11:0] c);
    return {1'b0, c[11:9], 1'b0, c[7:5], 1'b0, c[3:1]};
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s == 4'hF) ? 4'hF : s + 4'd1;
  endfunction

  assign scorer_score = scorer_q ? score2_q : score1_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    score1_d   = score1_q;
    score2_d   = score2_q;
    scorer_d   = scorer_q;
    flash_on_d = flash_on_q;
    unique case (state_q)
      StIdle: begin
        if (start_btn) begin
          state_d = StServe;
          cnt_d   = ServeCnt;
        end
      end
      StServe: begin
        if (frame_tick) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q <= 8'd1) state_d = StPlay;
        end
      end
      StPlay: begin
        if (score1_evt || score2_evt) begin
          // Player 1 wins a simultaneous score.
          if (score1_evt) begin
            score1_d = sat_inc(score1_q);
            scorer_d = 1'b0;
          end else begin
            score2_d = sat_inc(score2_q);
            scorer_d = 1'b1;
          end
          flash_on_d = 1'b1;
          cnt_d      = FlashCnt;
          state_d    = StFlash;
        end else if (pause_btn) begin
          state_d = StPause;
        end
      end
      StFlash: begin
        if (frame_tick) begin
          cnt_d      = cnt_q - 8'd1;
          flash_on_d = ~flash_on_q;
          if (cnt_q <= 8'd1) begin
            if (scorer_score == WinScore) begin
              state_d = StOver;
            end else begin
              state_d = StServe;
              cnt_d   = ServeCnt;
            end
          end
        end
      end
      StPause: begin
        if (pause_btn) state_d = StPlay;
      end
      StOver: begin
        if (start_btn) begin
          score1_d = 4'd0;
          score2_d = 4'd0;
          state_d  = StServe;
          cnt_d    = ServeCnt;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode from the next state so they change on the same edge as the state.
  always_comb begin
    scorer_rgb = scorer_d ? Pad2Rgb : Pad1Rgb;
    pad1_d     = Pad1Rgb;
    pad2_d     = Pad2Rgb;
    ball_d     = BallRgb;
    bg_d       = BgRgb;
    run_d      = 1'b0;
    vis_d      = 1'b0;
    unique case (state_d)
      StPlay: begin
        run_d = 1'b1;
        vis_d = 1'b1;
      end
      StFlash: begin
        if (flash_on_d) bg_d = scorer_rgb;
      end
      StPause: begin
        vis_d = 1'b1;
        if (DimEn) begin
          pad1_d = dim(Pad1Rgb);
          pad2_d = dim(Pad2Rgb);
          ball_d = dim(BallRgb);
          bg_d   = dim(BgRgb);
        end
      end
      StOver:  bg_d = scorer_rgb;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= 8'd0;
      score1_q   <= 4'd0;
      score2_q   <= 4'd0;
      scorer_q   <= 1'b0;
      flash_on_q <= 1'b0;
      pad1_q     <= Pad1Rgb;
      pad2_q     <= Pad2Rgb;
      ball_q     <= BallRgb;
      bg_q       <= BgRgb;
      run_q      <= 1'b0;
      vis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      score1_q   <= score1_d;
      score2_q   <= score2_d;
      scorer_q   <= scorer_d;
      flash_on_q <= flash_on_d;
      pad1_q     <= pad1_d;
      pad2_q     <= pad2_d;
      ball_q     <= ball_d;
      bg_q       <= bg_d;
      run_q      <= run_d;
      vis_q      <= vis_d;
    end
  end

  assign pad1_rgb     = pad1_q;
  assign pad2_rgb     = pad2_q;
  assign ball_rgb     = ball_q;
  assign bg_rgb       = bg_q;
  assign game_run     = run_q;
  assign ball_visible = vis_q;
  assign score1       = score1_q;
  assign score2       = score2_q;

endmodule
